sin_tone_gen: RTL and testbench

Periodic tone/wobble generator that wraps the sine lookup table. It drives the table's 6-bit index through the 40-entry cycle at a programmable rate and consumes the 5-bit table output. It converts that output into a registered sample and a 1-bit PWM stream for the audio pin or sprite-wobble logic. The lookup table itself stays combinational and external; this block owns all sequencing around it.

---
 rtl/sin_tone_gen.sv | 51 +++++
 tb/tb_sin_tone_gen.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sin_tone_gen.sv
// sin_tone_gen: steps the 40-entry sine-table index every div+1 cycles (lut_idx out, lut_val in) and turns the table output into a clamped 0..29 sample (sample, sample_valid) and a 30-cycle-frame PWM bit (pwm_out); en gates, rst clears
module sin_tone_gen #(
  parameter int DIV_W = 16,
  parameter int LUT_LEN = 40,
  parameter int PWM_MAX = 29
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic [5:0]       lut_idx,
  input  logic [4:0]       lut_val,
  output logic [4:0]       sample,
  output logic             sample_valid,
  output logic             pwm_out
);
  localparam logic [5:0] idx_last = 6'(LUT_LEN - 1);
  localparam logic [4:0] pwm_last = 5'(PWM_MAX);
  logic [DIV_W-1:0] pre_cnt;
  logic [4:0] pwm_cnt;
  logic [4:0] clamped;
  logic step;
  logic reload;
  always_comb begin
    step = pre_cnt >= div;
    reload = pwm_cnt == '0;
    clamped = lut_val > pwm_last ? pwm_last : lut_val;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
      lut_idx <= '0;
      sample <= '0;
      sample_valid <= 1'b0;
      pwm_out <= 1'b0;
    end else if (!en) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
      sample_valid <= 1'b0;
      pwm_out <= 1'b0;
    end else begin
      pre_cnt <= step ? '0 : pre_cnt + 1'b1;
      lut_idx <= !step ? lut_idx : lut_idx >= idx_last ? '0 : lut_idx + 1'b1;
      pwm_cnt <= pwm_cnt >= pwm_last ? '0 : pwm_cnt + 1'b1;
      sample <= reload ? clamped : sample;
      sample_valid <= reload;
      pwm_out <= pwm_cnt < sample;
    end
  end
endmodule

// File: tb/tb_sin_tone_gen.sv
// tb_sin_tone_gen: randomized scoreboard bench for sin_tone_gen against a frame/phase arithmetic model
module tb_sin_tone_gen;
  logic clk = 0;
  logic rst = 0;
  logic en = 0;
  logic [15:0] div = '0;
  logic [5:0] lut_idx;
  logic [4:0] lut_val;
  logic [4:0] sample;
  logic sample_valid;
  logic pwm_out;
  logic [4:0] tab [64];
  logic const_mode = 0;
  logic [4:0] const_val = '0;
  logic want_const = 0;
  logic [4:0] want_val = '0;
  typedef struct packed {
    logic [5:0] idx;
    logic [4:0] smp;
    logic       v;
    logic       p;
  } exp_t;
  exp_t q[$];
  int sq[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int m_idx = 0, m_sample = 0, m_run = 0, m_since = 0;
  logic m_valid = 0, m_pwm = 0;
  sin_tone_gen dut (
    .clk(clk), .rst(rst), .en(en), .div(div), .lut_idx(lut_idx), .lut_val(lut_val),
    .sample(sample), .sample_valid(sample_valid), .pwm_out(pwm_out)
  );
  always #5 clk = ~clk;
  assign lut_val = const_mode ? const_val : tab[lut_idx];
  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, got, exp, $time);
    end
  endtask
  // Expected outputs after the next rising edge, derived from frame position and cycles since last step.
  task automatic step(input logic r, input logic e, input int d);
    int pos;
    int lv;
    @(negedge clk);
    rst = r;
    en = e;
    div = 16'(d);
    const_mode = want_const;
    const_val = want_val;
    lv = want_const ? int'(want_val) : int'(tab[m_idx]);
    if (r) begin
      m_idx = 0; m_sample = 0; m_valid = 0; m_pwm = 0; m_run = 0; m_since = 0;
    end else if (!e) begin
      m_run = 0; m_since = 0; m_valid = 0; m_pwm = 0;
    end else begin
      pos = m_run % 30;
      m_pwm = pos < m_sample;
      m_valid = pos == 0;
      if (m_valid) begin
        m_sample = lv > 29 ? 29 : lv;
        sq.push_back(m_sample);
      end
      if (m_since >= d) begin
        m_idx = (m_idx + 1) % 40;
        m_since = 0;
      end else m_since++;
      m_run++;
    end
    q.push_back('{idx: 6'(m_idx), smp: 5'(m_sample), v: m_valid, p: m_pwm});
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("lut_idx", int'(lut_idx), int'(mon_e.idx));
      chk("sample", int'(sample), int'(mon_e.smp));
      chk("sample_valid", int'(sample_valid), int'(mon_e.v));
      chk("pwm_out", int'(pwm_out), int'(mon_e.p));
    end
    if (sample_valid) begin
      if (sq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sample_valid_unexpected: got pulse with sample %0d expected no pulse at %0t", sample, $time);
      end else chk("sample_on_valid", int'(sample), sq.pop_front());
    end
  end
  initial begin
    int k;
    int d;
    logic e;
    for (int i = 0; i < 64; i++) tab[i] = i < 40 ? 5'($urandom_range(0, 31)) : 5'd0;
    tab[3] = 5'd30;
    tab[7] = 5'd31;
    step(1, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < 45; i++) step(0, 1, 0);
    for (int i = 0; i < 170; i++) step(0, 1, 3);
    for (k = 0; k < 20 && m_since != 5; k++) step(0, 1, 7);
    chk("reach_pre5", m_since, 5);
    for (int i = 0; i < 20; i++) step(0, 1, 2);
    step(0, 0, 2);
    want_const = 1; want_val = 5'd15;
    for (int i = 0; i < 95; i++) step(0, 1, 2);
    want_val = 5'd0;
    for (int i = 0; i < 65; i++) step(0, 1, 2);
    want_val = 5'd31;
    for (int i = 0; i < 65; i++) step(0, 1, 2);
    for (k = 0; k < 40 && m_run % 30 != 10; k++) step(0, 1, 2);
    chk("reach_pwm10", m_run % 30, 10);
    for (int i = 0; i < 5; i++) step(0, 0, 2);
    want_val = 5'd20;
    for (int i = 0; i < 40; i++) step(0, 1, 2);
    want_const = 0;
    for (k = 0; k < 400 && m_idx != 17; k++) step(0, 1, 5);
    chk("reach_idx17", m_idx, 17);
    step(1, 1, 5);
    step(1, 1, 5);
    for (int i = 0; i < 40; i++) step(0, 1, 5);
    d = 2;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) d = $urandom_range(0, 6);
      if ($urandom_range(0, 99) == 0) begin
        want_const = $urandom_range(0, 1) == 1;
        want_val = 5'($urandom_range(0, 31));
      end
      e = $urandom_range(0, 9) != 0;
      step($urandom_range(0, 299) == 0, e, d);
    end
    repeat (3) @(negedge clk);
    chk("pending_expect", q.size(), 0);
    chk("pending_samples", sq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
